multicycle_control: RTL

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/riscv_ctrl_pkg.sv | 56 +++++
 rtl/alu_decoder.sv | 31 +++
 rtl/multicycle_control.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/riscv_ctrl_pkg.sv
// Shared control definitions for the multicycle RISC-V controller and the ALU.
package riscv_ctrl_pkg;

  localparam int unsigned STATE_ENC_W = 4;
  localparam int unsigned OP_W        = 7;
  localparam int unsigned FUNCT3_W    = 3;
  localparam int unsigned ALUOP_W     = 2;
  localparam int unsigned ALUCTL_W    = 3;
  localparam int unsigned SEL_W       = 2;

  typedef enum logic [STATE_ENC_W-1:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9,
    JAL      = 4'd10
  } state_t;

  localparam logic [OP_W-1:0] OP_LW    = 7'b0000011;
  localparam logic [OP_W-1:0] OP_SW    = 7'b0100011;
  localparam logic [OP_W-1:0] OP_RTYPE = 7'b0110011;
  localparam logic [OP_W-1:0] OP_ITYPE = 7'b0010011;
  localparam logic [OP_W-1:0] OP_BEQ   = 7'b1100011;
  localparam logic [OP_W-1:0] OP_JAL   = 7'b1101111;

  localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 2'b00;
  localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 2'b01;
  localparam logic [ALUOP_W-1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [ALUCTL_W-1:0] ALU_ADD = 3'b000;
  localparam logic [ALUCTL_W-1:0] ALU_SUB = 3'b001;
  localparam logic [ALUCTL_W-1:0] ALU_AND = 3'b010;
  localparam logic [ALUCTL_W-1:0] ALU_OR  = 3'b011;
  localparam logic [ALUCTL_W-1:0] ALU_SLT = 3'b101;

  // Per-state Moore control word produced by the FSM decode.
  typedef struct packed {
    logic               pcUpdate;
    logic               branch;
    logic               adrSrc;
    logic               memWrite;
    logic               irWrite;
    logic               regWrite;
    logic [SEL_W-1:0]   resultSrc;
    logic [SEL_W-1:0]   aluSrcA;
    logic [SEL_W-1:0]   aluSrcB;
    logic [ALUOP_W-1:0] aluOp;
  } ctrl_t;

endpackage

// File: rtl/alu_decoder.sv
// Maps ALUOp plus instruction function fields onto the ALU operation code.
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic [ALUOP_W-1:0]  aluOp,
  input  logic [FUNCT3_W-1:0] funct3,
  input  logic                funct7b5,
  input  logic                opb5,
  output logic [ALUCTL_W-1:0] aluControl
);

  // Only R-type (op[5]=1) with funct7b5 selects subtract; addi never does.
  always_comb begin
    aluControl = ALU_ADD;
    case (aluOp)
      ALUOP_ADD: aluControl = ALU_ADD;
      ALUOP_SUB: aluControl = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000:  aluControl = (funct7b5 & opb5) ? ALU_SUB : ALU_ADD;
          3'b010:  aluControl = ALU_SLT;
          3'b110:  aluControl = ALU_OR;
          3'b111:  aluControl = ALU_AND;
          default: aluControl = ALU_ADD;
        endcase
      end
      default: aluControl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle RISC-V main controller: Moore FSM, immediate select and ALU decode.
module multicycle_control
  import riscv_ctrl_pkg::*;
#(
  parameter int unsigned STATE_W = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OP_W-1:0]     op,
  input  logic [FUNCT3_W-1:0] funct3,
  input  logic                funct7b5,
  input  logic                zero,
  output logic                PCWrite,
  output logic                AdrSrc,
  output logic                MemWrite,
  output logic                IRWrite,
  output logic                RegWrite,
  output logic [SEL_W-1:0]    ResultSrc,
  output logic [SEL_W-1:0]    ALUSrcA,
  output logic [SEL_W-1:0]    ALUSrcB,
  output logic [SEL_W-1:0]    ImmSrc,
  output logic [ALUCTL_W-1:0] ALUControl
);

  logic [STATE_W-1:0] stateQ;
  logic [STATE_W-1:0] stateD;
  logic [STATE_W-1:0] decState;
  ctrl_t              ctrl;

  // State register with synchronous reset into FETCH.
  always_ff @(posedge clk) begin
    if (reset) stateQ <= STATE_W'(FETCH);
    else       stateQ <= stateD;
  end

  // Next-state logic; unencoded states recover to FETCH.
  always_comb begin
    stateD = STATE_W'(FETCH);
    case (stateQ)
      STATE_W'(FETCH):  stateD = STATE_W'(DECODE);
      STATE_W'(DECODE): begin
        case (op)
          OP_LW, OP_SW: stateD = STATE_W'(MEMADR);
          OP_RTYPE:     stateD = STATE_W'(EXECUTER);
          OP_ITYPE:     stateD = STATE_W'(EXECUTEI);
          OP_BEQ:       stateD = STATE_W'(BEQ);
          OP_JAL:       stateD = STATE_W'(JAL);
          default:      stateD = STATE_W'(FETCH);
        endcase
      end
      STATE_W'(MEMADR):   stateD = (op == OP_LW) ? STATE_W'(MEMREAD) : STATE_W'(MEMWRITE);
      STATE_W'(MEMREAD):  stateD = STATE_W'(MEMWB);
      STATE_W'(EXECUTER): stateD = STATE_W'(ALUWB);
      STATE_W'(EXECUTEI): stateD = STATE_W'(ALUWB);
      STATE_W'(JAL):      stateD = STATE_W'(ALUWB);
      default:            stateD = STATE_W'(FETCH);
    endcase
  end

  // Moore control word; while reset is held the FETCH word is shown.
  always_comb begin
    ctrl     = '0;
    decState = reset ? STATE_W'(FETCH) : stateQ;
    case (decState)
      STATE_W'(FETCH): begin
        ctrl.irWrite   = 1'b1;
        ctrl.aluSrcB   = 2'b10;
        ctrl.resultSrc = 2'b10;
        ctrl.pcUpdate  = 1'b1;
      end
      STATE_W'(DECODE): begin
        ctrl.aluSrcA = 2'b01;
        ctrl.aluSrcB = 2'b01;
      end
      STATE_W'(MEMADR): begin
        ctrl.aluSrcA = 2'b10;
        ctrl.aluSrcB = 2'b01;
      end
      STATE_W'(MEMREAD): ctrl.adrSrc = 1'b1;
      STATE_W'(MEMWRITE): begin
        ctrl.adrSrc   = 1'b1;
        ctrl.memWrite = 1'b1;
      end
      STATE_W'(MEMWB): begin
        ctrl.resultSrc = 2'b01;
        ctrl.regWrite  = 1'b1;
      end
      STATE_W'(EXECUTER): begin
        ctrl.aluSrcA = 2'b10;
        ctrl.aluOp   = ALUOP_FUNCT;
      end
      STATE_W'(EXECUTEI): begin
        ctrl.aluSrcA = 2'b10;
        ctrl.aluSrcB = 2'b01;
        ctrl.aluOp   = ALUOP_FUNCT;
      end
      STATE_W'(ALUWB): ctrl.regWrite = 1'b1;
      STATE_W'(BEQ): begin
        ctrl.aluSrcA = 2'b10;
        ctrl.aluOp   = ALUOP_SUB;
        ctrl.branch  = 1'b1;
      end
      STATE_W'(JAL): begin
        ctrl.aluSrcA  = 2'b01;
        ctrl.aluSrcB  = 2'b10;
        ctrl.pcUpdate = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

  // Datapath enables are suppressed during reset; selects pass through.
  always_comb begin
    PCWrite   = ~reset & (ctrl.pcUpdate | (ctrl.branch & zero));
    MemWrite  = ~reset & ctrl.memWrite;
    IRWrite   = ~reset & ctrl.irWrite;
    RegWrite  = ~reset & ctrl.regWrite;
    AdrSrc    = ctrl.adrSrc;
    ResultSrc = ctrl.resultSrc;
    ALUSrcA   = ctrl.aluSrcA;
    ALUSrcB   = ctrl.aluSrcB;
  end

  // Immediate format select straight from the opcode.
  always_comb begin
    ImmSrc = 2'b00;
    case (op)
      OP_SW:   ImmSrc = 2'b01;
      OP_BEQ:  ImmSrc = 2'b10;
      OP_JAL:  ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

  alu_decoder u_aluDecoder (
    .aluOp      (ctrl.aluOp),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .opb5       (op[5]),
    .aluControl (ALUControl)
  );

endmodule
